rs_frame_ctrl: RTL
==================

RS_FRAME_CTRL -- requirements
Module: rs_frame_ctrl

Interface
REQ-001 Parameter CW_LEN, default 204, codeword length in bytes (RS(204,188)).
REQ-002 Parameter LOCK_CNT, default 3, consecutive good sync bytes needed to declare lock.
REQ-003 Parameter UNLOCK_CNT, default 3, consecutive bad sync bytes needed to drop lock.
REQ-004 Clk  input  1  system clock, all logic on rising edge.
REQ-005 Reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  in_data carries a byte this cycle.
REQ-007 in_data  input  8  byte stream from the deinterleaver.
REQ-008 dec_ready  input  1  RS decoder can accept a new codeword.
REQ-009 out_valid  output  1  out_data is a codeword byte for the decoder.
REQ-010 out_data  output  8  forwarded byte.
REQ-011 out_idx  output  8  byte index within codeword, 0..CW_LEN-1.
REQ-012 out_sop  output  1  first byte of codeword (idx 0).
REQ-013 out_eop  output  1  last byte of codeword (idx CW_LEN-1).
REQ-014 out_inv_sync  output  1  with out_sop: sync byte was 0xB8 (inverted), else 0x47.
REQ-015 locked  output  1  FSM in LOCKED.
REQ-016 drop_cnt  output  16  codewords discarded because dec_ready was low.

Function
REQ-017 Sync byte SHALL be 0x47 or 0xB8; any other value is a sync mismatch.
REQ-018 Byte counter SHALL advance only on in_valid, wrap CW_LEN-1 -> 0, hold during in_valid gaps.
REQ-019 FSM states SHALL be HUNT, VERIFY, LOCKED.
REQ-020 HUNT: valid sync byte -> VERIFY, counter set so next byte is idx 1, good count = 1; otherwise stay.
REQ-021 VERIFY: at idx 0 with sync match, good count +1; on reaching LOCK_CNT -> LOCKED; mismatch -> HUNT.
REQ-022 LOCKED: at idx 0, match clears miss count, mismatch increments it; miss count reaching UNLOCK_CNT -> HUNT.
REQ-023 Sync checks SHALL occur only at idx 0; lock loss therefore never truncates a forwarded codeword.
REQ-024 Codeword admission SHALL be decided at idx 0 while LOCKED (including the byte completing lock? no: the LOCKED state must already hold before that byte): dec_ready=1 admits all CW_LEN bytes, dec_ready=0 discards them all.
REQ-025 dec_ready deasserting mid-codeword SHALL NOT abort an admitted codeword.
REQ-026 A codeword whose idx-0 byte is a sync mismatch in LOCKED SHALL still be forwarded if admitted (decoder handles errors).
REQ-027 drop_cnt SHALL increment once per discarded codeword, saturating at 0xFFFF.
REQ-028 Outputs SHALL be registered, latency exactly 1 cycle from in_valid byte to out_valid.
REQ-029 out_valid SHALL be 0 in HUNT and VERIFY and for discarded codewords; out_data/out_idx don't-care then.
REQ-030 locked SHALL update 1 cycle after the state transition.

Reset
REQ-031 Reset SHALL force HUNT, counter 0, good/miss counts 0, drop_cnt 0, admit flag 0.
REQ-032 Reset value of every output SHALL be 0; Reset mid-codeword terminates it without out_eop.

Structure
REQ-033 Package rs_dvbt_pkg SHALL hold CW_LEN, K_LEN (188), SYNC_BYTE (0x47), SYNC_INV (0xB8) and the FSM state enum.
REQ-034 One sub-module rs_cw_counter (modulo-CW_LEN byte counter with load, wrap, idx0/last flags) is natural; FSM and admission logic stay in rs_frame_ctrl.

Verification
REQ-035 4 continuous codewords, byte 0 = 0x47, dec_ready=1 -> locked rises after 3rd sync; 4th codeword forwarded with out_sop on 0x47 and out_eop at idx 203.
REQ-036 Locked stream, 3 consecutive codewords with byte 0 = 0x00 -> locked drops after 3rd; those 3 codewords still forwarded whole.
REQ-037 Locked, dec_ready=0 at idx 0 for 2 codewords then 1 -> 408 bytes without out_valid, drop_cnt = 2, next codeword forwarded.
REQ-038 Locked, in_valid toggling 1/0 every cycle -> out_idx increments only on valid bytes, 1-cycle latency preserved.
REQ-039 Byte 0 = 0xB8 on every 8th codeword -> out_inv_sync=1 with that out_sop, lock maintained.
REQ-040 Reset asserted at idx 100 of a forwarded codeword -> next cycle all outputs 0, state HUNT, relock needs 3 syncs.

Source files
------------

// File: rtl/rs_dvbt_pkg.sv
// Shared constants and types for the DVB-T RS(204,188) front end.
package rs_dvbt_pkg;

  localparam int CW_LEN = 204;
  localparam int K_LEN  = 188;
  localparam int IDX_W  = 8;
  localparam int DROP_W = 16;

  localparam logic [7:0] SYNC_BYTE = 8'h47;
  localparam logic [7:0] SYNC_INV  = 8'hB8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

  typedef struct packed {
    logic             valid;
    logic [7:0]       data;
    logic [IDX_W-1:0] idx;
    logic             sop;
    logic             eop;
    logic             inv_sync;
  } cw_beat_t;

  function automatic logic is_sync(input logic [7:0] b);
    return (b == SYNC_BYTE) || (b == SYNC_INV);
  endfunction

endpackage

// File: rtl/rs_cw_counter.sv
// Modulo-N byte position counter with load; flags first and last position.
module rs_cw_counter
  import rs_dvbt_pkg::*;
#(
  parameter int N_BYTES = 204
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_adv,
  input  logic             i_load,
  input  logic [IDX_W-1:0] i_load_val,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_idx0,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BYTES - 1);

  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge Clk) begin
    if (Reset)       r_idx <= '0;
    else if (i_load) r_idx <= i_load_val;
    else if (i_adv)  r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
  end

  assign o_idx  = r_idx;
  assign o_idx0 = (r_idx == '0);
  assign o_last = (r_idx == LAST);

endmodule

// File: rtl/rs_frame_ctrl.sv
// Sync-byte framer: hunts/verifies/locks on codeword sync bytes and forwards
// whole codewords to the RS decoder when it is ready at the codeword start.
module rs_frame_ctrl #(
  parameter int CW_LEN     = rs_dvbt_pkg::CW_LEN,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 3
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  input  logic                           dec_ready,
  output logic                           out_valid,
  output logic [7:0]                     out_data,
  output logic [rs_dvbt_pkg::IDX_W-1:0]  out_idx,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic                           out_inv_sync,
  output logic                           locked,
  output logic [rs_dvbt_pkg::DROP_W-1:0] drop_cnt
);
  import rs_dvbt_pkg::*;

  localparam logic [7:0]       LOCK_N   = 8'(LOCK_CNT);
  localparam logic [7:0]       UNLOCK_N = 8'(UNLOCK_CNT);
  localparam logic [IDX_W-1:0] LOAD_IDX = (CW_LEN > 1) ? IDX_W'(1) : '0;

  sync_state_e       r_state, w_state_nxt;
  logic [7:0]        r_good, w_good_nxt;
  logic [7:0]        r_miss, w_miss_nxt;
  logic              r_admit;
  logic              r_locked;
  logic [DROP_W-1:0] r_drop;
  cw_beat_t          r_beat, w_beat;

  logic [IDX_W-1:0]  w_idx;
  logic              w_idx0, w_last;
  logic              w_sync_ok, w_hunting, w_load, w_adv, w_cw_start, w_fwd;

  assign w_sync_ok  = is_sync(in_data);
  // An admitted codeword runs to completion after lock loss; the hunt only
  // starts once its tail has been forwarded.
  assign w_hunting  = (r_state == HUNT) && !r_admit;
  assign w_adv      = in_valid && !w_hunting;
  assign w_cw_start = in_valid && w_idx0 && (r_state == LOCKED);
  assign w_fwd      = in_valid && (w_idx0 ? ((r_state == LOCKED) && dec_ready) : r_admit);

  rs_cw_counter #(.N_BYTES(CW_LEN)) u_cnt (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_adv      (w_adv),
    .i_load     (w_load),
    .i_load_val (LOAD_IDX),
    .o_idx      (w_idx),
    .o_idx0     (w_idx0),
    .o_last     (w_last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= HUNT;
      r_good  <= '0;
      r_miss  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_load      = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (in_valid && w_hunting && w_sync_ok) begin
          w_load      = 1'b1;
          w_good_nxt  = 8'd1;
          w_miss_nxt  = '0;
          w_state_nxt = (LOCK_N <= 8'd1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (in_valid && w_idx0) begin
          if (w_sync_ok) begin
            w_good_nxt = r_good + 8'd1;
            if (w_good_nxt >= LOCK_N) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_state_nxt = HUNT;
            w_good_nxt  = '0;
          end
        end
      end
      LOCKED: begin
        if (in_valid && w_idx0) begin
          if (w_sync_ok) begin
            w_miss_nxt = '0;
          end else begin
            w_miss_nxt = r_miss + 8'd1;
            if (w_miss_nxt >= UNLOCK_N) begin
              w_state_nxt = HUNT;
              w_miss_nxt  = '0;
              w_good_nxt  = '0;
            end
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // Admission is latched at idx 0 and held until the last byte, so dec_ready
  // changes mid-codeword neither abort nor start a codeword.
  always_ff @(posedge Clk) begin
    if (Reset)         r_admit <= 1'b0;
    else if (in_valid) r_admit <= w_fwd && !w_last;
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      r_drop <= '0;
    else if (w_cw_start && !dec_ready && (r_drop != {DROP_W{1'b1}}))
      r_drop <= r_drop + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_locked <= 1'b0;
    else       r_locked <= (r_state == LOCKED);
  end

  always_comb begin
    w_beat          = r_beat;
    w_beat.valid    = w_fwd;
    w_beat.sop      = w_fwd && w_idx0;
    w_beat.eop      = w_fwd && w_last;
    w_beat.inv_sync = w_fwd && w_idx0 && (in_data == SYNC_INV);
    if (w_fwd) begin
      w_beat.data = in_data;
      w_beat.idx  = w_idx;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_beat <= '0;
    else       r_beat <= w_beat;
  end

  assign out_valid    = r_beat.valid;
  assign out_data     = r_beat.data;
  assign out_idx      = r_beat.idx;
  assign out_sop      = r_beat.sop;
  assign out_eop      = r_beat.eop;
  assign out_inv_sync = r_beat.inv_sync;
  assign locked       = r_locked;
  assign drop_cnt     = r_drop;

endmodule
